// File: rtl/evm_vote_tally.sv
`default_nettype none
// ============================================================================
//  Module   : evm_vote_tally
//  Purpose  : Front end of the EVM candidate display path. Raw candidate
//             push-buttons are synchronised and debounced. A lockout FSM
//             accepts one vote per press. Per-candidate tallies saturate at
//             their maximum value. The selected tally is presented as a
//             registered count for the seven-segment decoder.
//  Ports    : clk       - system clock, rising edge
//             rst_n     - asynchronous active-low reset
//             enable    - poll open; votes are counted only while high
//             clear     - synchronous tally clear (pulse or level)
//             vote_btn  - raw asynchronous candidate buttons, active-high
//             sel       - candidate index to display
//             count     - registered tally of candidate sel (0 if sel invalid)
//             vote_ack  - one-cycle pulse when a vote is counted
//             busy      - high whenever the FSM is not in IDLE
//             sat       - sticky, set on an increment attempt at full scale
//             leader    - lowest index holding the maximum tally (optional)
//             tie       - two or more candidates share a nonzero max (optional)
//  Options  : define EVM_LEADER_OUT_EN to add the leader/tie outputs.
//  Revision : 1.0 - initial release
// ============================================================================
module evm_vote_tally #(
   parameter int NUM_CAND     = 4,
   parameter int CNT_W        = 3,
   parameter int DEBOUNCE_CYC = 16,
   parameter int LOCK_CYC     = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                enable,
   input  logic                clear,
   input  logic [NUM_CAND-1:0] vote_btn,
   input  logic [2:0]          sel,
   output logic [CNT_W-1:0]    count,
   output logic                vote_ack,
   output logic                busy,
   output logic                sat
`ifdef EVM_LEADER_OUT_EN
   ,
   output logic [2:0]          leader,
   output logic                tie
`endif
);

   localparam int DB_W = $clog2(DEBOUNCE_CYC);
   localparam int LK_W = $clog2(LOCK_CYC + 1);
   localparam logic [CNT_W-1:0] TALLY_MAX = '1;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      ACCEPT   = 3'd1,
      REJECT   = 3'd2,
      LOCK     = 3'd3,
      WAIT_REL = 3'd4
   } state_t;

   state_t              state, state_nx;
   logic [NUM_CAND-1:0] deb;
   logic                any_hi, one_hot, multi_hi;
   logic [2:0]          pick_idx, pick_q;
   logic [LK_W-1:0]     lock_cnt;
   logic [CNT_W-1:0]    tally [NUM_CAND];
   logic [CNT_W-1:0]    sel_tally;

   // ---------------------------------------------------------------------
   // Per-button 2-flop synchroniser and debounce filter. The debounced
   // level only flips after the synced input has disagreed with it for
   // DEBOUNCE_CYC consecutive cycles; any agreement restarts the count.
   // ---------------------------------------------------------------------
   for (genvar i = 0; i < NUM_CAND; i++) begin : g_btn
      logic            s1, s2, lvl;
      logic [DB_W-1:0] db_cnt;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            lvl    <= 1'b0;
            db_cnt <= '0;
         end else begin
            s1 <= vote_btn[i];
            s2 <= s1;
            if (s2 == lvl) begin
               db_cnt <= '0;
            end else if (db_cnt == DB_W'(DEBOUNCE_CYC - 1)) begin
               lvl    <= ~lvl;
               db_cnt <= '0;
            end else begin
               db_cnt <= db_cnt + 1'b1;
            end
         end
      end

      assign deb[i] = lvl;
   end

   // Exactly one bit set <=> nonzero and clearing the lowest set bit leaves 0
   assign any_hi   = |deb;
   assign one_hot  = any_hi && ((deb & (deb - 1'b1)) == '0);
   assign multi_hi = any_hi && !one_hot;

   always_comb begin
      pick_idx = '0;
      for (int i = 0; i < NUM_CAND; i++) begin
         if (deb[i]) pick_idx = 3'(i);
      end
   end

   // ---------------------------------------------------------------------
   // Lockout FSM
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         pick_q   <= '0;
         lock_cnt <= '0;
      end else begin
         state <= state_nx;
         // Candidate index is frozen on the IDLE cycle that launches ACCEPT
         if (state == IDLE) pick_q <= pick_idx;
         if (state == LOCK) lock_cnt <= lock_cnt + 1'b1;
         else               lock_cnt <= '0;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (enable && one_hot)       state_nx = ACCEPT;
            else if (enable && multi_hi) state_nx = REJECT;
         end
         ACCEPT:   state_nx = LOCK;
         REJECT:   state_nx = WAIT_REL;
         LOCK: begin
            if (lock_cnt == LK_W'(LOCK_CYC - 1)) state_nx = WAIT_REL;
         end
         WAIT_REL: begin
            if (!any_hi) state_nx = IDLE;
         end
         default:  state_nx = IDLE;
      endcase
      // Clear parks the FSM until every button is released
      if (clear) state_nx = WAIT_REL;
   end

   // A clear landing on the ACCEPT cycle wins: the vote is dropped unacked
   assign vote_ack = (state == ACCEPT) && !clear;
   assign busy     = (state != IDLE);

   // ---------------------------------------------------------------------
   // Saturating tallies and sticky saturation flag
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_CAND; i++) tally[i] <= '0;
         sat <= 1'b0;
      end else if (clear) begin
         for (int i = 0; i < NUM_CAND; i++) tally[i] <= '0;
         sat <= 1'b0;
      end else if (vote_ack) begin
         for (int i = 0; i < NUM_CAND; i++) begin
            if (pick_q == 3'(i)) begin
               if (tally[i] == TALLY_MAX) sat <= 1'b1;
               else                       tally[i] <= tally[i] + 1'b1;
            end
         end
      end
   end

   // Out-of-range selections fall through with the zero default
   always_comb begin
      sel_tally = '0;
      for (int i = 0; i < NUM_CAND; i++) begin
         if (sel == 3'(i)) sel_tally = tally[i];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) count <= '0;
      else        count <= sel_tally;
   end

`ifdef EVM_LEADER_OUT_EN
   // ---------------------------------------------------------------------
   // Leader / tie detection. Strict '>' keeps the lowest index on ties.
   // ---------------------------------------------------------------------
   logic [CNT_W-1:0] max_v;
   logic [2:0]       lead_c;
   logic [3:0]       n_max;

   always_comb begin
      max_v  = '0;
      lead_c = '0;
      n_max  = '0;
      for (int i = 0; i < NUM_CAND; i++) begin
         if (tally[i] > max_v) begin
            max_v  = tally[i];
            lead_c = 3'(i);
         end
      end
      for (int i = 0; i < NUM_CAND; i++) begin
         if (tally[i] == max_v) n_max = n_max + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         leader <= '0;
         tie    <= 1'b0;
      end else if (clear) begin
         leader <= '0;
         tie    <= 1'b0;
      end else begin
         leader <= lead_c;
         tie    <= (n_max >= 4'd2) && (max_v != '0);
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_evm_vote_tally.sv
`default_nettype none
// ============================================================================
//  Module   : tb_evm_vote_tally
//  Purpose  : Directed self-checking bench for evm_vote_tally (default build,
//             default parameters). Expected values are hand-derived.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_evm_vote_tally;

   logic       clk;
   logic       rst_n;
   logic       enable;
   logic       clear;
   logic [3:0] vote_btn;
   logic [2:0] sel;
   logic [2:0] count;
   logic       vote_ack;
   logic       busy;
   logic       sat;

   int n_vec;
   int n_err;
   int ack_cnt;
   int a0;

   evm_vote_tally #(
      .NUM_CAND     (4),
      .CNT_W        (3),
      .DEBOUNCE_CYC (16),
      .LOCK_CYC     (8)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .enable   (enable),
      .clear    (clear),
      .vote_btn (vote_btn),
      .sel      (sel),
      .count    (count),
      .vote_ack (vote_ack),
      .busy     (busy),
      .sat      (sat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Acks are sampled on the falling edge, away from state changes
   always @(negedge clk) begin
      if (rst_n && vote_ack) ack_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Advance n rising edges and land 1 ns after the last one
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic press(input logic [3:0] btn, input int hold, input int rel);
      vote_btn = btn;
      tick(hold);
      vote_btn = 4'b0000;
      tick(rel);
   endtask

   task automatic chk_tallies(input string tag, input logic [2:0] e0, input logic [2:0] e1,
                              input logic [2:0] e2, input logic [2:0] e3);
      logic [2:0] exp_t [4];
      exp_t[0] = e0; exp_t[1] = e1; exp_t[2] = e2; exp_t[3] = e3;
      for (int s = 0; s < 4; s++) begin
         sel = 3'(s);
         tick(2);
         chk($sformatf("%s_t%0d", tag, s), 32'(count), 32'(exp_t[s]));
      end
   endtask

   initial begin
      n_vec    = 0;
      n_err    = 0;
      ack_cnt  = 0;
      rst_n    = 1'b0;
      enable   = 1'b0;
      clear    = 1'b0;
      vote_btn = 4'b0000;
      sel      = 3'd0;

      // ---------------- reset state ----------------
      #12;
      chk("rst_count", 32'(count), 0);
      chk("rst_busy",  32'(busy), 0);
      chk("rst_ack",   32'(vote_ack), 0);
      chk("rst_sat",   32'(sat), 0);
      tick(1);
      rst_n  = 1'b1;
      enable = 1'b1;
      sel    = 3'd1;
      tick(1);

      // ---------------- clean press, latency ----------------
      a0 = ack_cnt;
      vote_btn = 4'b0010;          // changes just after edge E
      tick(18);
      chk("ack_early", 32'(vote_ack), 0);
      tick(1);                     // edge E+19
      chk("ack_lat",  32'(vote_ack), 1);
      chk("busy_acc", 32'(busy), 1);
      tick(21);
      vote_btn = 4'b0000;
      tick(5);
      chk("busy_rel", 32'(busy), 1);
      tick(30);
      chk("busy_idle",  32'(busy), 0);
      chk("p1_count",   32'(count), 1);
      chk("p1_acks",    32'(ack_cnt - a0), 1);

      // ---------------- bounce ----------------
      sel = 3'd0;
      a0  = ack_cnt;
      for (int i = 0; i < 12; i++) begin
         vote_btn[0] = ~vote_btn[0];
         tick(5);
      end
      press(4'b0001, 30, 30);
      chk("bnc_acks",  32'(ack_cnt - a0), 1);
      chk("bnc_count", 32'(count), 1);

      // ---------------- simultaneous ----------------
      a0 = ack_cnt;
      vote_btn = 4'b0101;
      tick(25);
      chk("sim_busy", 32'(busy), 1);
      tick(15);
      vote_btn = 4'b0000;
      tick(30);
      chk("sim_acks", 32'(ack_cnt - a0), 0);
      chk("sim_idle", 32'(busy), 0);
      chk_tallies("sim", 3'd1, 3'd1, 3'd0, 3'd0);

      // ---------------- saturation ----------------
      sel = 3'd3;
      a0  = ack_cnt;
      for (int p = 1; p <= 9; p++) begin
         press(4'b1000, 25, 25);
         if (p == 7) begin
            chk("sat_p7",   32'(sat), 0);
            chk("cnt_p7",   32'(count), 7);
         end
         if (p == 8) chk("sat_p8", 32'(sat), 1);
      end
      chk("sat_count", 32'(count), 7);
      chk("sat_acks",  32'(ack_cnt - a0), 9);
      chk("sat_hold",  32'(sat), 1);

      // ---------------- clear vs held button ----------------
      press(4'b0001, 25, 25);      // tallies {2,1,0,7}
      chk_tallies("pre_clr", 3'd2, 3'd1, 3'd0, 3'd7);
      sel = 3'd2;
      a0  = ack_cnt;
      vote_btn = 4'b0100;
      tick(19);                    // ACCEPT cycle
      chk("clr_pre_ack", 32'(vote_ack), 1);
      clear = 1'b1;
      #1;
      chk("clr_prio_ack", 32'(vote_ack), 0);
      tick(1);
      clear = 1'b0;
      tick(30);                    // still holding
      chk("clr_hold_acks", 32'(ack_cnt - a0), 0);
      chk("clr_hold_busy", 32'(busy), 1);
      chk("clr_sat",       32'(sat), 0);
      vote_btn = 4'b0000;
      tick(30);
      chk_tallies("post_clr", 3'd0, 3'd0, 3'd0, 3'd0);
      a0 = ack_cnt;
      sel = 3'd2;
      press(4'b0100, 25, 25);
      chk("new_acks",  32'(ack_cnt - a0), 1);
      chk("new_count", 32'(count), 1);

      // ---------------- enable low blocks votes ----------------
      enable = 1'b0;
      a0 = ack_cnt;
      press(4'b0100, 30, 30);
      chk("dis_acks",  32'(ack_cnt - a0), 0);
      chk("dis_count", 32'(count), 1);
      chk("dis_busy",  32'(busy), 0);
      enable = 1'b1;

      // ---------------- async reset mid-LOCK ----------------
      vote_btn = 4'b0100;
      tick(19);
      chk("lk_ack", 32'(vote_ack), 1);
      tick(3);                     // in LOCK, tally 2 now 2
      chk("lk_count", 32'(count), 2);
      chk("lk_busy",  32'(busy), 1);
      #3;
      rst_n = 1'b0;
      #1;
      chk("ar_count", 32'(count), 0);
      chk("ar_busy",  32'(busy), 0);
      chk("ar_ack",   32'(vote_ack), 0);
      vote_btn = 4'b0000;
      tick(2);
      rst_n = 1'b1;
      tick(3);
      chk("ar_tally", 32'(count), 0);
      chk("ar_idle",  32'(busy), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Safety net so the run always terminates
   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      n_err++;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
